wshb_mire: RTL and testbench

// - Test-pattern ("mire") generator: Wishbone master on sys_clk that writes one

---
 rtl/wshb_mire.sv | 160 ++++++++++++++++
 tb/tb_wshb_mire.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_mire.sv
// Wishbone test-pattern ("mire") generator: writes a grid pattern over the whole framebuffer, yielding the bus every BURST_LEN writes.
// Optional feature: define MIRE_ANIMATE_EN to scroll the vertical grid lines by one pixel per frame.
module wshb_mire #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int BURST_LEN = 64,
    parameter int GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    output logic [3:0]  wb_sel,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic        frame_done,
    output logic        busy
);

    localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int OW = $clog2(GRID);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [XW-1:0]   x_r;
    logic [XW-1:0]   x_nxt_s;
    logic [YW-1:0]   y_r;
    logic [YW-1:0]   y_nxt_s;
    logic [31:0]     pix_r;
    logic [31:0]     pix_nxt_s;
    logic [BW-1:0]   burst_r;
    logic [BW-1:0]   burst_nxt_s;
    logic [OW-1:0]   off_nxt_s;
    logic            adv_s;
    logic            burst_end_s;
    logic            frame_end_s;
    logic            stb_nxt_s;

    // Grid rule: white on every GRID-th column (shifted by the scroll offset) and every GRID-th row.
    function automatic logic [31:0] mire_pixel(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                               input logic [OW-1:0] off);
        logic [OW-1:0] xs;
        logic [OW-1:0] ys;
        xs = OW'(32'(x)) + off;
        ys = OW'(32'(y));
        if ((xs == '0) || (ys == '0)) begin
            return 32'h00FF_FFFF;
        end else begin
            return 32'h0000_0000;
        end
    endfunction

    // Next pixel position, burst count and FSM state; an error cycle never advances anything.
    always_comb begin
        adv_s       = (state_r == WRITE) && wb_ack && !wb_err;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        pix_nxt_s   = pix_r;
        burst_nxt_s = burst_r;
        frame_end_s = 1'b0;
        burst_end_s = 1'b0;
        state_nxt_s = state_r;
        if (adv_s) begin
            if (x_r == XW'(HDISP - 1)) begin
                x_nxt_s = '0;
                if (y_r == YW'(VDISP - 1)) begin
                    y_nxt_s     = '0;
                    pix_nxt_s   = 32'd0;
                    frame_end_s = 1'b1;
                end else begin
                    y_nxt_s   = y_r + YW'(1);
                    pix_nxt_s = pix_r + 32'd1;
                end
            end else begin
                x_nxt_s   = x_r + XW'(1);
                pix_nxt_s = pix_r + 32'd1;
            end
            burst_end_s = (burst_r == BW'(BURST_LEN - 1));
            burst_nxt_s = burst_end_s ? '0 : burst_r + BW'(1);
        end else begin
            burst_nxt_s = burst_r;
        end
        case (state_r)
            IDLE:    state_nxt_s = enable ? WRITE : IDLE;
            WRITE:   state_nxt_s = burst_end_s ? PAUSE : WRITE;
            PAUSE:   state_nxt_s = enable ? WRITE : IDLE;
            default: state_nxt_s = IDLE;
        endcase
        stb_nxt_s = (state_nxt_s == WRITE);
    end

`ifdef MIRE_ANIMATE_EN
    logic [OW-1:0] off_r;

    // Scroll offset advances together with the frame_done pulse.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            off_r <= '0;
        end else begin
            off_r <= off_nxt_s;
        end
    end

    // Offset seen by the next pixel already includes a wrap that happens this cycle.
    always_comb begin
        off_nxt_s = frame_end_s ? off_r + OW'(1) : off_r;
    end
`else
    // Static pattern: no scroll.
    always_comb begin
        off_nxt_s = '0;
    end
`endif

    // State, position and registered bus outputs; address/data are loaded from the next position.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r    <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            pix_r      <= 32'd0;
            burst_r    <= '0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_sel     <= 4'h0;
            wb_adr     <= 32'd0;
            wb_dat_ms  <= 32'd0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            x_r        <= x_nxt_s;
            y_r        <= y_nxt_s;
            pix_r      <= pix_nxt_s;
            burst_r    <= burst_nxt_s;
            wb_cyc     <= stb_nxt_s;
            wb_stb     <= stb_nxt_s;
            wb_we      <= stb_nxt_s;
            wb_sel     <= stb_nxt_s ? 4'hF : 4'h0;
            wb_adr     <= stb_nxt_s ? (pix_nxt_s << 2) : 32'd0;
            wb_dat_ms  <= stb_nxt_s ? mire_pixel(x_nxt_s, y_nxt_s, off_nxt_s) : 32'd0;
            frame_done <= frame_end_s;
            busy       <= (state_nxt_s != IDLE);
        end
    end

endmodule

// File: tb/tb_wshb_mire.sv
// Scoreboard bench for wshb_mire on a reduced 40x8 frame; a monitor pops expected writes as the slave accepts them.
module tb_wshb_mire;
    localparam int H = 40;
    localparam int V = 8;
    localparam int B = 64;
    localparam int G = 16;
    localparam int N = H * V;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable    = 1'b0;
    logic        wb_ack    = 1'b0;
    logic        wb_err    = 1'b0;
    logic        wb_cyc, wb_stb, wb_we, frame_done, busy;
    logic [31:0] wb_adr, wb_dat_ms;
    logic [3:0]  wb_sel;

    wshb_mire #(.HDISP(H), .VDISP(V), .BURST_LEN(B), .GRID(G)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_ms(wb_dat_ms), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0;
    int          fall_cnt = 0;
    int          err_cnt = 0;
    int          frame_cnt = 0;
    int          low_run = 0;
    int          cyc = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_acc_adr = 32'd0;
    logic        pause_chk_en = 1'b0;
    int          ack_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] pix_dat(input int frame, input int p);
        int x, y, off;
        x = p % H;
        y = p / H;
`ifdef MIRE_ANIMATE_EN
        off = frame % G;
`else
        off = 0 * frame;
`endif
        return ((((x + off) % G) == 0) || ((y % G) == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
    endfunction

    task automatic push_pixels(input int frame, input int first, input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back({32'((first + i) * 4), pix_dat(frame, first + i)});
        end
    endtask

    // Monitor: bus-rule checks every cycle, scoreboard pop on each accepted write.
    logic        prev_stb = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_adr = 32'd0;
    logic [31:0] prev_dat = 32'd0;
    always @(negedge sys_clk) begin
        logic  acc;
        xfer_t e;
        cyc++;
        acc = 1'b0;
        if (!sys_rst_n) begin
            acc_cnt  = 0;
            low_run  = 0;
            prev_stb = 1'b0;
            prev_acc = 1'b0;
        end else begin
            if (frame_done) begin
                frame_cnt++;
                chk("frame_done_adr", last_acc_adr, 32'((N - 1) * 4));
                chk("frame_done_lat", 32'(cyc - last_acc_cyc), 32'd1);
            end
            if (wb_stb) begin
                chk("stb_ctrl", {29'd0, wb_cyc, wb_we, 1'b0} | {28'd0, wb_sel}, 32'h0000_000F | 32'h6);
                if (prev_stb && !prev_acc) begin
                    chk("hold_adr", wb_adr, prev_adr);
                    chk("hold_dat", wb_dat_ms, prev_dat);
                end
                if (!prev_stb && pause_chk_en) chk("pause_len", 32'(low_run), 32'd1);
                if (wb_err) err_cnt++;
                acc = wb_ack && !wb_err;
                if (acc) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", wb_adr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_adr", wb_adr, e.adr);
                        chk("wr_dat", wb_dat_ms, e.dat);
                    end
                    acc_cnt++;
                    last_acc_adr = wb_adr;
                    last_acc_cyc = cyc;
                end
                low_run = 0;
            end else begin
                chk("idle_ctrl", {27'd0, wb_cyc, wb_we, wb_sel}, 32'd0);
                if (prev_stb) begin
                    fall_cnt++;
                    chk("burst_boundary", 32'(acc_cnt % B), 32'd0);
                end
                low_run++;
            end
            prev_stb = wb_stb;
            prev_acc = acc;
            prev_adr = wb_adr;
            prev_dat = wb_dat_ms;
        end
    end

    // Slave responder: mode 0 acks every cycle; mode 1 inserts 3 wait states and one error on adr 8.
    initial begin
        int   wait_n;
        logic err_done;
        wait_n   = 0;
        err_done = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (ack_mode == 0) begin
                wb_ack = 1'b1;
                wb_err = 1'b0;
            end else if (!wb_stb) begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
                wait_n = 0;
            end else if (wait_n < 3) begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
                wait_n++;
            end else if (wb_adr == 32'd8 && !err_done) begin
                wb_ack   = 1'b1;
                wb_err   = 1'b1;
                err_done = 1'b1;
                wait_n   = 0;
            end else begin
                wb_ack = 1'b1;
                wb_err = 1'b0;
                wait_n = 0;
            end
        end
    end

    task automatic wait_acc(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (acc_cnt < target && n < budget) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (acc_cnt < target) chk(name, 32'(acc_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        if (busy) chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        enable    = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_ctrl", {26'd0, wb_cyc, wb_stb, wb_we, frame_done, busy, |wb_sel}, 32'd0);
        chk("reset_adr", wb_adr, 32'd0);
        chk("reset_dat", wb_dat_ms, 32'd0);

        // Full frame plus part of the next, slave acking every cycle.
        push_pixels(0, 0, N);
        push_pixels(1, 0, 100);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("latency_idle", {31'd0, wb_stb}, 32'd0);
        @(posedge sys_clk);
        #1;
        chk("latency_stb", {31'd0, wb_stb}, 32'd1);
        chk("first_adr", wb_adr, 32'd0);
        chk("first_dat", wb_dat_ms, 32'h00FF_FFFF);
        pause_chk_en = 1'b1;
        wait_acc(N + 100, 2000, "frame_timeout");

        // Reset while strobing mid-frame.
        chk("pre_reset_stb", {31'd0, wb_stb}, 32'd1);
        sys_rst_n    = 1'b0;
        pause_chk_en = 1'b0;
        exp_q.delete();
        @(posedge sys_clk);
        #1;
        chk("rst_mid_ctrl", {26'd0, wb_cyc, wb_stb, wb_we, frame_done, busy, |wb_sel}, 32'd0);
        chk("rst_mid_adr", wb_adr, 32'd0);
        chk("rst_mid_dat", wb_dat_ms, 32'd0);
        chk("frame_cnt", 32'(frame_cnt), 32'd1);
        chk("pause_cnt", 32'(fall_cnt), 32'((N + 100) / B));

        // Restart at pixel 0 with wait states, one error, and enable dropped at write 10.
        ack_mode = 1;
        push_pixels(0, 0, B);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        wait_acc(10, 2000, "waits_timeout");
        enable = 1'b0;
        wait_idle(2000, "idle_timeout");
        repeat (3) @(posedge sys_clk);
        #1;
        chk("stop_count", 32'(acc_cnt), 32'(B));
        chk("err_seen", 32'(err_cnt), 32'd1);
        chk("stop_stb", {31'd0, wb_stb}, 32'd0);
        chk("stop_queue", 32'(exp_q.size()), 32'd0);

        // Resume one burst from the kept position.
        ack_mode = 0;
        push_pixels(0, B, B);
        enable = 1'b1;
        @(posedge sys_clk);
        #1;
        enable = 1'b0;
        chk("resume_adr", wb_adr, 32'd256);
        wait_idle(2000, "resume_timeout");
        repeat (3) @(posedge sys_clk);
        #1;
        chk("resume_count", 32'(acc_cnt), 32'(2 * B));
        chk("resume_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
